// File: rtl/bar_graph_pkg.sv
// Shared constants and types for the bar-graph level meter renderer.
package bar_graph_pkg;

  // Screen geometry
  localparam int ScreenW   = 96;
  localparam int ScreenH   = 64;
  localparam int NumPixels = ScreenW * ScreenH;

  // Bar area origin, horizontal extent and vertical segment pitch
  localparam int BarX0     = 8;
  localparam int BarY0     = 8;
  localparam int BarExtent = 80;
  localparam int SegPitch  = 3;

  typedef enum logic [1:0] {
    BorderOff   = 2'b00,
    BorderThin  = 2'b01,
    BorderThick = 2'b10
  } border_e;

  typedef enum logic [1:0] {
    StTrack = 2'b00,
    StHold  = 2'b01,
    StDecay = 2'b10
  } peak_st_e;

  typedef struct packed {
    logic [15:0] bg;
    logic [15:0] fg;
    logic [15:0] red;
    logic [15:0] green;
    logic [15:0] yellow;
  } palette_t;

  function automatic palette_t palette_lookup(input logic [1:0] sel);
    palette_t p;
    case (sel)
      2'b00:   p = '{bg: 16'h0000, fg: 16'hFFFF, red: 16'hF800, green: 16'h07E0, yellow: 16'hFFE0};
      2'b01:   p = '{bg: 16'h0000, fg: 16'hFFFF, red: 16'hF800, green: 16'h001F, yellow: 16'hF81F};
      2'b10:   p = '{bg: 16'hFFFF, fg: 16'h0000, red: 16'h001F, green: 16'h07E0, yellow: 16'h07FF};
      default: p = '{bg: 16'hFFFF, fg: 16'h0000, red: 16'hF800, green: 16'h07E0, yellow: 16'hFFE0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/peak_tracker.sv
// Per-channel peak-hold marker: holds a new peak, then decays one segment at a time.
module peak_tracker
  import bar_graph_pkg::*;
#(
  parameter int unsigned SegW         = 5,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            frame_start,
  input  logic [SegW-1:0] level,
  output logic [SegW-1:0] peak
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int unsigned DcntW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  peak_st_e         state_q, state_d;
  logic [SegW-1:0]  peak_q, peak_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;

  // State register with asynchronous reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= StTrack;
      peak_q  <= '0;
      hold_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next state: only frame_start advances the tracker
  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    dcnt_d  = dcnt_q;
    if (frame_start) begin
      if (level >= peak_q) begin
        // A new (or equal) peak restarts the hold from any state
        peak_d  = level;
        hold_d  = HoldW'(HOLD_FRAMES);
        state_d = (level == '0) ? StTrack : StHold;
      end else begin
        unique case (state_q)
          StHold: begin
            if (hold_q != '0) begin
              hold_d = hold_q - HoldW'(1);
            end else begin
              state_d = StDecay;
              dcnt_d  = DcntW'(DECAY_FRAMES - 1);
            end
          end
          StDecay: begin
            if (dcnt_q != '0) begin
              dcnt_d = dcnt_q - DcntW'(1);
            end else begin
              dcnt_d = DcntW'(DECAY_FRAMES - 1);
              // level < peak here, so peak-1 cannot underflow
              if (peak_q - SegW'(1) <= level) begin
                peak_d  = level;
                state_d = StTrack;
              end else begin
                peak_d = peak_q - SegW'(1);
              end
            end
          end
          default: peak_d = level;
        endcase
      end
    end
  end

  // Output: the registered peak
  always_comb begin
    peak = peak_q;
  end

endmodule

// File: rtl/bar_graph_visualiser.sv
// Multi-channel segmented level meter for a 96x64 RGB565 raster, 2-cycle pixel latency.
module bar_graph_visualiser
  import bar_graph_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned NUM_SEG      = 16,
  parameter int unsigned LEVEL_W      = 5,
  parameter int unsigned RED_FROM     = 11,
  parameter int unsigned YELLOW_FROM  = 5,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      frame_start,
  input  logic [12:0]               pixel_index,
  input  logic [NUM_CH*LEVEL_W-1:0] level_in,
  input  logic [1:0]                border_mode,
  input  logic [1:0]                colour_mode,
  input  logic                      peak_en,
  output logic [15:0]               oled_data
);

  localparam int unsigned SegW  = $clog2(NUM_SEG + 1);
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          SlotW = BarExtent / int'(NUM_CH);

  if (NUM_SEG < 1 || NUM_SEG > 17) begin : g_bad_seg
    $error("NUM_SEG must be in 1..17");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH must be in 1..8");
  end

  logic [SegW-1:0] level_clamped [NUM_CH];
  logic [SegW-1:0] shadow_q      [NUM_CH];
  logic [SegW-1:0] peak          [NUM_CH];

  // Clamp each incoming level to the number of segments
  always_comb begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (32'(level_in[c*LEVEL_W +: LEVEL_W]) > NUM_SEG) begin
        level_clamped[c] = SegW'(NUM_SEG);
      end else begin
        level_clamped[c] = SegW'(level_in[c*LEVEL_W +: LEVEL_W]);
      end
    end
  end

  // Shadow levels change only at frame start so a frame never tears
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < int'(NUM_CH); c++) shadow_q[c] <= '0;
    end else if (frame_start) begin
      for (int c = 0; c < int'(NUM_CH); c++) shadow_q[c] <= level_clamped[c];
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_peak
    peak_tracker #(
      .SegW         (SegW),
      .HOLD_FRAMES  (HOLD_FRAMES),
      .DECAY_FRAMES (DECAY_FRAMES)
    ) u_peak (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .frame_start (frame_start),
      .level       (level_clamped[g]),
      .peak        (peak[g])
    );
  end

  logic [6:0] x_q, y_q;
  logic       valid_q;

  // Stage 1: split the raster index into coordinates
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= 7'(pixel_index % 13'(ScreenW));
      y_q     <= 7'(pixel_index / 13'(ScreenW));
      valid_q <= pixel_index < 13'(NumPixels);
    end
  end

  int              xi, yi;
  logic            border_hit, seg_hit, col_hit;
  logic [SegW-1:0] seg_idx;
  logic [ChW-1:0]  ch_idx;

  // Geometry decode: border, segment row and bar column hits
  always_comb begin
    xi         = int'(x_q);
    yi         = int'(y_q);
    border_hit = 1'b0;
    if (border_mode[1]) begin
      border_hit = (xi < 3) || (yi < 3) || (xi > ScreenW - 4) || (yi > ScreenH - 4);
    end else if (border_mode == BorderThin) begin
      border_hit = (xi == 0) || (yi == 0) || (xi == ScreenW - 1) || (yi == ScreenH - 1);
    end
    seg_hit = 1'b0;
    seg_idx = '0;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      if (yi == BarY0 + SegPitch * k || yi == BarY0 + SegPitch * k + 1) begin
        seg_hit = 1'b1;
        seg_idx = SegW'(int'(NUM_SEG) - 1 - k);
      end
    end
    col_hit = 1'b0;
    ch_idx  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (xi >= BarX0 + c * SlotW + 2 && xi <= BarX0 + c * SlotW + SlotW - 3) begin
        col_hit = 1'b1;
        ch_idx  = ChW'(c);
      end
    end
  end

  palette_t    pal;
  logic [15:0] colour;

  // Stage 2 colour select: bg < border < bar, peak marker over lit segments
  always_comb begin
    pal    = palette_lookup(colour_mode);
    colour = pal.bg;
    if (valid_q) begin
      if (border_hit) colour = pal.fg;
      if (seg_hit && col_hit) begin
        if (peak_en && peak[ch_idx] != '0 && seg_idx == peak[ch_idx] - SegW'(1)) begin
          colour = pal.fg;
        end else if (seg_idx < shadow_q[ch_idx]) begin
          if (32'(seg_idx) >= RED_FROM)         colour = pal.red;
          else if (32'(seg_idx) >= YELLOW_FROM) colour = pal.yellow;
          else                                  colour = pal.green;
        end else begin
          colour = pal.bg;
        end
      end
    end
  end

  // Output register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) oled_data <= '0;
    else       oled_data <= colour;
  end

endmodule

// File: tb/tb_bar_graph_visualiser.sv
// Self-checking bench for bar_graph_visualiser against a frame-level reference model.
module tb_bar_graph_visualiser;

  localparam int NUM_CH       = 4;
  localparam int NUM_SEG      = 16;
  localparam int LEVEL_W      = 5;
  localparam int RED_FROM     = 11;
  localparam int YELLOW_FROM  = 5;
  localparam int HOLD_FRAMES  = 30;
  localparam int DECAY_FRAMES = 4;
  localparam int SLOT         = 80 / NUM_CH;

  // Palette table: bg, fg, red, green, yellow
  localparam logic [15:0] PAL [4][5] = '{
    '{16'h0000, 16'hFFFF, 16'hF800, 16'h07E0, 16'hFFE0},
    '{16'h0000, 16'hFFFF, 16'hF800, 16'h001F, 16'hF81F},
    '{16'hFFFF, 16'h0000, 16'h001F, 16'h07E0, 16'h07FF},
    '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'hFFE0}
  };

  logic                      CLOCK = 1'b0;
  logic                      RESET;
  logic                      frame_start;
  logic [12:0]               pixel_index;
  logic [NUM_CH*LEVEL_W-1:0] level_in;
  logic [1:0]                border_mode;
  logic [1:0]                colour_mode;
  logic                      peak_en;
  logic [15:0]               oled_data;

  always #5 CLOCK = ~CLOCK;

  bar_graph_visualiser #(
    .NUM_CH       (NUM_CH),
    .NUM_SEG      (NUM_SEG),
    .LEVEL_W      (LEVEL_W),
    .RED_FROM     (RED_FROM),
    .YELLOW_FROM  (YELLOW_FROM),
    .HOLD_FRAMES  (HOLD_FRAMES),
    .DECAY_FRAMES (DECAY_FRAMES)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .frame_start (frame_start),
    .pixel_index (pixel_index),
    .level_in    (level_in),
    .border_mode (border_mode),
    .colour_mode (colour_mode),
    .peak_en     (peak_en),
    .oled_data   (oled_data)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: displayed level, peak, and peak phase per channel
  int shadow_m [NUM_CH];
  int peak_m   [NUM_CH];
  int phase_m  [NUM_CH];  // 0 following, 1 holding, 2 decaying
  int hold_m   [NUM_CH];
  int dcnt_m   [NUM_CH];
  int lv_set   [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_m[c] = 0; peak_m[c] = 0; phase_m[c] = 0; hold_m[c] = 0; dcnt_m[c] = 0;
    end
  endtask

  task automatic model_frame();
    int l;
    for (int c = 0; c < NUM_CH; c++) begin
      l = (lv_set[c] > NUM_SEG) ? NUM_SEG : lv_set[c];
      shadow_m[c] = l;
      if (l >= peak_m[c]) begin
        peak_m[c]  = l;
        hold_m[c]  = HOLD_FRAMES;
        phase_m[c] = (l == 0) ? 0 : 1;
      end else if (phase_m[c] == 1) begin
        if (hold_m[c] != 0) hold_m[c]--;
        else begin phase_m[c] = 2; dcnt_m[c] = DECAY_FRAMES - 1; end
      end else if (phase_m[c] == 2) begin
        if (dcnt_m[c] != 0) dcnt_m[c]--;
        else begin
          dcnt_m[c] = DECAY_FRAMES - 1;
          if (peak_m[c] - 1 <= l) begin peak_m[c] = l; phase_m[c] = 0; end
          else peak_m[c] = peak_m[c] - 1;
        end
      end else begin
        peak_m[c] = l;
      end
    end
  endtask

  function automatic logic [15:0] exp_pixel(input int pidx, input logic [1:0] bm,
                                            input logic [1:0] cm, input logic pe);
    int x, y, c, off, k, r, s;
    logic [15:0] col;
    if (pidx >= 6144) return PAL[cm][0];
    x = pidx % 96;
    y = pidx / 96;
    col = PAL[cm][0];
    if (bm == 2'b01 && (x == 0 || y == 0 || x == 95 || y == 63)) col = PAL[cm][1];
    if (bm[1] && (x < 3 || y < 3 || x > 92 || y > 60)) col = PAL[cm][1];
    if (x >= 8 && x < 88 && y >= 8) begin
      c = (x - 8) / SLOT;
      off = (x - 8) % SLOT;
      k = (y - 8) / 3;
      r = (y - 8) % 3;
      if (c < NUM_CH && off >= 2 && off <= SLOT - 3 && k < NUM_SEG && r < 2) begin
        s = NUM_SEG - 1 - k;
        if (pe && peak_m[c] > 0 && s == peak_m[c] - 1) col = PAL[cm][1];
        else if (s < shadow_m[c]) col = (s >= RED_FROM) ? PAL[cm][2] :
                                        (s >= YELLOW_FROM) ? PAL[cm][4] : PAL[cm][3];
        else col = PAL[cm][0];
      end
    end
    return col;
  endfunction

  function automatic int pix(input int x, input int y);
    return y * 96 + x;
  endfunction

  // Row of the upper line of segment s
  function automatic int seg_row(input int s);
    return 8 + 3 * (NUM_SEG - 1 - s);
  endfunction

  task automatic render(input int pidx, output logic [15:0] got);
    @(negedge CLOCK);
    pixel_index = 13'(pidx);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1 got = oled_data;
  endtask

  task automatic do_frame();
    @(negedge CLOCK);
    for (int c = 0; c < NUM_CH; c++) level_in[c*LEVEL_W +: LEVEL_W] = LEVEL_W'(lv_set[c]);
    frame_start = 1'b1;
    @(negedge CLOCK);
    frame_start = 1'b0;
    model_frame();
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [15:0] got;
    #1;
    cmp_cnt++;
    if (oled_data !== 16'h0000) begin
      $display("FAIL reset_init: got %h want 0000", oled_data); err_cnt++;
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    model_reset();
    render(pix(10, 8), got);
    cmp_cnt++;
    if (got !== 16'h0000) begin $display("FAIL reset_bg: got %h want 0000", got); err_cnt++; end
    lv_set = '{16, 16, 16, 16};
    do_frame();
    render(pix(10, 8), got);
    cmp_cnt++;
    if (got !== 16'hF800) begin $display("FAIL pre_reset_red: got %h want F800", got); err_cnt++; end
    // Assert reset mid-stream, together with a frame_start carrying nonzero levels
    @(negedge CLOCK);
    RESET = 1'b1;
    frame_start = 1'b1;
    #1;
    cmp_cnt++;
    if (oled_data !== 16'h0000) begin
      $display("FAIL reset_async: got %h want 0000", oled_data); err_cnt++;
    end
    @(negedge CLOCK);
    frame_start = 1'b0;
    RESET = 1'b0;
    model_reset();
    render(pix(10, 8), got);
    cmp_cnt++;
    if (got !== 16'h0000) begin $display("FAIL reset_top_bg: got %h want 0000", got); err_cnt++; end
    render(pix(10, 53), got);
    cmp_cnt++;
    if (got !== 16'h0000) begin $display("FAIL reset_wins_fs: got %h want 0000", got); err_cnt++; end
  endtask

  task automatic test_levels();
    int          xs   [6] = '{10, 10, 10, 10, 30, 12};
    int          ys   [6] = '{8, 26, 53, 10, 8, 54};
    logic [15:0] want [6] = '{16'hF800, 16'hFFE0, 16'h07E0, 16'h0000, 16'hF800, 16'h07E0};
    logic [15:0] got;
    border_mode = 2'b00; colour_mode = 2'b00; peak_en = 1'b0;
    lv_set = '{16, 20, 7, 3};
    do_frame();
    for (int i = 0; i < 6; i++) begin
      render(pix(xs[i], ys[i]), got);
      cmp_cnt++;
      if (got !== want[i]) begin
        $display("FAIL levels(%0d,%0d): got %h want %h", xs[i], ys[i], got, want[i]); err_cnt++;
      end
    end
    // Level change without frame_start must not reach the screen
    level_in = '0;
    render(pix(10, 8), got);
    cmp_cnt++;
    if (got !== 16'hF800) begin $display("FAIL no_latch: got %h want F800", got); err_cnt++; end
  endtask

  task automatic test_border();
    logic [1:0]  bms  [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [1:0]  cms  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    int          xs   [6] = '{0, 1, 2, 3, 95, 0};
    logic [15:0] want [6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] got;
    for (int i = 0; i < 6; i++) begin
      border_mode = bms[i]; colour_mode = cms[i];
      render(pix(xs[i], 30), got);
      cmp_cnt++;
      if (got !== want[i]) begin
        $display("FAIL border(%0d,30) bm=%0d: got %h want %h", xs[i], bms[i], got, want[i]);
        err_cnt++;
      end
    end
    border_mode = 2'b01; colour_mode = 2'b10;
    render(pix(1, 30), got);
    cmp_cnt++;
    if (got !== 16'hFFFF) begin $display("FAIL pal10_bg: got %h want FFFF", got); err_cnt++; end
    border_mode = 2'b00; colour_mode = 2'b00;
  endtask

  task automatic test_peak_directed();
    logic [15:0] got, want;
    pulse_reset();
    border_mode = 2'b00; colour_mode = 2'b00; peak_en = 1'b1;
    lv_set = '{10, 0, 0, 0};
    do_frame();
    lv_set = '{0, 0, 0, 0};
    for (int f = 1; f <= 80; f++) begin
      if (f > 1) do_frame();
      render(pix(12, 26), got);
      want = exp_pixel(pix(12, 26), 2'b00, 2'b00, 1'b1);
      if (f <= 31) want = 16'hFFFF;
      cmp_cnt++;
      if (got !== want) begin
        $display("FAIL peak_hold frame %0d: got %h want %h", f, got, want); err_cnt++;
      end
      if (peak_m[0] > 0) begin
        render(pix(12, seg_row(peak_m[0] - 1) + 1), got);
        cmp_cnt++;
        if (got !== 16'hFFFF) begin
          $display("FAIL peak_marker frame %0d: got %h want FFFF", f, got); err_cnt++;
        end
      end
    end
    render(pix(12, seg_row(0)), got);
    cmp_cnt++;
    if (got !== 16'h0000) begin $display("FAIL peak_gone: got %h want 0000", got); err_cnt++; end
  endtask

  task automatic test_peak_random();
    logic [15:0] got, want;
    int p;
    peak_en = 1'b1; border_mode = 2'b00;
    for (int f = 0; f < 250; f++) begin
      for (int c = 0; c < NUM_CH; c++)
        lv_set[c] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      do_frame();
      colour_mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < 2; j++) begin
          if (j == 0 && peak_m[c] > 0)
            p = pix(8 + c * SLOT + 2 + $urandom_range(0, SLOT - 5), seg_row(peak_m[c] - 1));
          else
            p = pix(8 + c * SLOT + $urandom_range(0, SLOT - 1), $urandom_range(8, 8 + 3 * NUM_SEG));
          render(p, got);
          want = exp_pixel(p, border_mode, colour_mode, peak_en);
          cmp_cnt++;
          if (got !== want) begin
            $display("FAIL peak_rand f=%0d pix=%0d: got %h want %h", f, p, got, want); err_cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_random_render();
    logic [15:0] got, want;
    int p;
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < NUM_CH; c++) lv_set[c] = $urandom_range(0, 31);
      do_frame();
      border_mode = 2'($urandom_range(0, 3));
      colour_mode = 2'($urandom_range(0, 3));
      peak_en     = 1'($urandom_range(0, 1));
      for (int j = 0; j < 20; j++) begin
        p = $urandom_range(0, 8191);
        render(p, got);
        want = exp_pixel(p, border_mode, colour_mode, peak_en);
        cmp_cnt++;
        if (got !== want) begin
          $display("FAIL render pix=%0d bm=%0d cm=%0d pe=%0d: got %h want %h",
                   p, border_mode, colour_mode, peak_en, got, want);
          err_cnt++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [$];
    logic [15:0] want;
    int p;
    border_mode = 2'b10; colour_mode = 2'b01; peak_en = 1'b1;
    for (int i = 0; i < 302; i++) begin
      @(negedge CLOCK);
      if (i >= 2) begin
        want = q.pop_front();
        cmp_cnt++;
        if (oled_data !== want) begin
          $display("FAIL stream i=%0d: got %h want %h", i, oled_data, want); err_cnt++;
        end
      end
      if (i < 300) begin
        p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8191) : $urandom_range(768, 5000);
        pixel_index = 13'(p);
        q.push_back(exp_pixel(p, border_mode, colour_mode, peak_en));
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; frame_start = 1'b0; pixel_index = '0; level_in = '0;
    border_mode = 2'b00; colour_mode = 2'b00; peak_en = 1'b0;
    test_reset();
    test_levels();
    test_border();
    test_peak_directed();
    test_peak_random();
    test_random_render();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
